// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds the controller state encoding and the Booth digit decode so the
// selector and the controller agree on one definition.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  // Map a 3-bit overlapping multiplier group {q[i+1], q[i], q[i-1]} to its digit.
  function automatic digit_t booth_digit(input logic [2:0] group);
    digit_t d;
    case (group)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Combinational radix-4 Booth partial-product selector.
// Produces d*M sign-extended to WIDTH+2 bits, which is wide enough to hold
// +-2M even for the most negative multiplicand.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       group,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] m_dbl;

  assign m_ext = {{2{m[WIDTH-1]}}, m};
  assign m_dbl = {m_ext[WIDTH:0], 1'b0};

  // Select the signed multiple of M named by the decoded Booth digit.
  always_comb begin
    pp = '0;
    case (booth_digit(group))
      POS1:    pp = m_ext;
      POS2:    pp = m_dbl;
      NEG1:    pp = -m_ext;
      NEG2:    pp = -m_dbl;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per cycle
// through booth_pp_sel and returns the exact 2*WIDTH-bit signed product.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 2 - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;

  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_m1_next;

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .group ({q_reg[1:0], q_m1}),
    .m     (m_reg),
    .pp    (pp)
  );

  // One Booth step: add the partial product, then arithmetic-shift {A,Q,q-1} right by two.
  always_comb begin
    sum       = acc + pp;
    acc_next  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    q_next    = {sum[1:0], q_reg[WIDTH-1:2]};
    q_m1_next = q_reg[1];
  end

  // Controller FSM with the datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      product <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            acc   <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            m_reg <= multiplicand;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q_reg <= q_next;
          q_m1  <= q_m1_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            state   <= DONE;
            product <= {acc_next[WIDTH-1:0], q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult at WIDTH=16: directed table vectors,
// hand-written start-while-busy and mid-run reset sequences, and randomized
// back-to-back transactions checked against a plain-arithmetic product model.
module tb_booth_seq_mult;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accept_cycle = 0;

  typedef struct {
    string          name;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter used to measure issue intervals.
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference product from signed integer arithmetic.
  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] m, input logic [W-1:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p[2*W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one transaction and follow it to completion, checking timing and result.
  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q,
                               input logic [2*W-1:0] exp, input string name);
    int waits;
    int k;
    int busy_cnt;
    bit seen_done;
    waits = 0;
    while (!ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    checkOutput({name, "_ready_before"}, 64'(ready), 64'd1);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    accept_cycle = cyc;
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    k = 0;
    busy_cnt = 0;
    seen_done = 1'b0;
    while (k < 40) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      k++;
    end
    checkOutput({name, "_done_seen"}, 64'(seen_done), 64'd1);
    checkOutput({name, "_latency"}, 64'(k), 64'(W / 2));
    checkOutput({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W / 2));
    checkOutput({name, "_product"}, 64'(product), 64'(exp));
    @(posedge clk); #1;
    checkOutput({name, "_done_pulse_width"}, 64'(done), 64'd0);
    checkOutput({name, "_ready_after"}, 64'(ready), 64'd1);
    checkOutput({name, "_product_hold"}, 64'(product), 64'(exp));
  endtask

  initial begin
    int done_cnt;
    int busy_after_done;
    int prev_accept;
    logic [W-1:0] rm;
    logic [W-1:0] rq;

    vecs[0] = '{"basic_3x5",      16'd3,      16'd5,      32'h0000_000F};
    vecs[1] = '{"most_negative",  16'h8000,   16'h8000,   32'h4000_0000};
    vecs[2] = '{"neg1_x_1",       16'hFFFF,   16'h0001,   32'hFFFF_FFFF};
    vecs[3] = '{"max_x_min",      16'h7FFF,   16'h8000,   32'hC000_8000};
    vecs[4] = '{"zero_x_neg",     16'h0000,   16'hABCD,   32'h0000_0000};
    vecs[5] = '{"min_x_max",      16'h8000,   16'h7FFF,   32'hC000_8000};

    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", 64'(product), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].m, vecs[i].q, vecs[i].exp, vecs[i].name);
    end

    // Start pulsed while busy must be ignored.
    multiplicand = 16'd2;
    multiplier   = 16'd3;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    busy_after_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_cnt++;
      if (busy && done_cnt > 0) busy_after_done++;
      @(posedge clk); #1;
    end
    checkOutput("busy_start_done_count", 64'(done_cnt), 64'd1);
    checkOutput("busy_start_product", 64'(product), 64'h0000_0006);
    checkOutput("busy_start_no_second_run", 64'(busy_after_done), 64'd0);

    // Reset in the middle of a run discards the operation.
    multiplicand = 16'd100;
    multiplier   = 16'd100;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_ready", 64'(ready), 64'd1);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_product", 64'(product), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);
    applyStimulus(16'hFFF9, 16'd6, 32'hFFFF_FFD6, "after_reset_m7x6");

    // Randomized back-to-back transactions at the minimum issue interval.
    prev_accept = 0;
    for (int i = 0; i < 30; i++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      if (i == 0) rm = 16'h8000;
      if (i == 1) rq = 16'h8000;
      applyStimulus(rm, rq, refProduct(rm, rq), $sformatf("rand%0d", i));
      if (i > 0) begin
        checkOutput($sformatf("rand%0d_issue_interval", i),
                    64'(accept_cycle - prev_accept), 64'(W / 2 + 2));
      end
      prev_accept = accept_cycle;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
